// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing, sync polarity type and a helper for total line/frame size.
// Holds only constants, types and a pure function, so there is no latency or backpressure.
package vga_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   typedef enum logic {
      POL_LOW  = 1'b0,
      POL_HIGH = 1'b1
   } sync_pol_e;

   function automatic int unsigned timing_total(
      input int unsigned active,
      input int unsigned fp,
      input int unsigned sync,
      input int unsigned bp
   );
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Wrapping up-counter, 0..MAX, with a synchronous clear that has priority over the enable.
// The count updates one clk after en/clr are seen; it never stalls its source.
module vga_timing_gen_counter #(
   parameter int unsigned W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         rst_L,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= (q == MAX) ? '0 : q + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, coordinates, strobes, frame count, vblank irq.
// Outputs are registered and lag the counters by 1 clk; en=0 freezes counters and holds the levels.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
   parameter int unsigned H_FP      = VGA_H_FP,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BP      = VGA_H_BP,
   parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
   parameter int unsigned V_FP      = VGA_V_FP,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BP      = VGA_V_BP,
   parameter sync_pol_e   HSYNC_POL = POL_LOW,
   parameter sync_pol_e   VSYNC_POL = POL_LOW,
   parameter int          CLK_DIV   = 1,
   parameter int          SCAN_DIV  = 2,
   parameter int unsigned CW        = 10
) (
   input  logic          clk,
   input  logic          rst_L,
   input  logic          en,
   input  logic          irq_ack,
   output logic          HSync,
   output logic          VSync,
   output logic          active,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          pix_tick,
   output logic          line_start,
   output logic          frame_start,
   output logic          scanline_en,
   output logic          vblank_irq,
   output logic [7:0]    frame_count
);

   localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic          HS_ON    = logic'(HSYNC_POL);
   localparam logic          VS_ON    = logic'(VSYNC_POL);

   generate
      if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0)) begin : g_cw_check
         $error("vga_timing_gen: CW cannot hold H_TOTAL-1 or V_TOTAL-1");
      end
      if ((CLK_DIV < 1) || (SCAN_DIV < 1)) begin : g_div_check
         $error("vga_timing_gen: CLK_DIV and SCAN_DIV must be at least 1");
      end
   endgenerate

   logic [DW-1:0] div_q;
   logic [CW-1:0] h_q;
   logic [CW-1:0] v_q;
   logic [SW-1:0] s_q;

   logic tick;
   logic line_end;
   logic frame_end;
   logic h_vis;
   logic v_vis;
   logic hs_in;
   logic vs_in;
   logic h_first;
   logic irq_set;

   assign tick      = en && (div_q == DIV_LAST);
   assign line_end  = tick && (h_q == H_LAST);
   assign frame_end = line_end && (v_q == V_LAST);
   assign h_vis     = (h_q < H_ACT);
   assign v_vis     = (v_q < V_ACT);
   assign hs_in     = (h_q >= HS_BEG) && (h_q <= HS_LAST);
   assign vs_in     = (v_q >= VS_BEG) && (v_q <= VS_LAST);
   assign h_first   = (h_q == '0);
   assign irq_set   = tick && h_first && (v_q == V_ACT);

   vga_timing_gen_counter #(.W(DW), .MAX(DIV_LAST)) u_div (
      .clk   (clk),
      .rst_L (rst_L),
      .clr   (1'b0),
      .en    (en),
      .q     (div_q)
   );

   vga_timing_gen_counter #(.W(CW), .MAX(H_LAST)) u_h (
      .clk   (clk),
      .rst_L (rst_L),
      .clr   (1'b0),
      .en    (tick),
      .q     (h_q)
   );

   vga_timing_gen_counter #(.W(CW), .MAX(V_LAST)) u_v (
      .clk   (clk),
      .rst_L (rst_L),
      .clr   (1'b0),
      .en    (line_end),
      .q     (v_q)
   );

   // Cleared at frame wrap so a V_ACTIVE that is not a multiple of SCAN_DIV re-aligns every frame.
   vga_timing_gen_counter #(.W(SW), .MAX(S_LAST)) u_s (
      .clk   (clk),
      .rst_L (rst_L),
      .clr   (frame_end),
      .en    (line_end && v_vis),
      .q     (s_q)
   );

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         HSync       <= ~HS_ON;
         VSync       <= ~VS_ON;
         active      <= 1'b0;
         row         <= '0;
         col         <= '0;
         pix_tick    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         scanline_en <= 1'b0;
         vblank_irq  <= 1'b0;
         frame_count <= '0;
      end else begin
         pix_tick    <= tick;
         line_start  <= tick && h_first;
         frame_start <= tick && h_first && (v_q == '0);
         scanline_en <= line_end && v_vis && (s_q == S_LAST);
         // Levels only reload while running so a paused raster keeps showing its last pixel.
         if (en) begin
            HSync  <= hs_in ? HS_ON : ~HS_ON;
            VSync  <= vs_in ? VS_ON : ~VS_ON;
            active <= h_vis && v_vis;
            col    <= (h_vis && v_vis) ? h_q : '0;
            row    <= (h_vis && v_vis) ? v_q : '0;
         end
         if (irq_set) begin
            vblank_irq <= 1'b1;
         end else if (irq_ack) begin
            vblank_irq <= 1'b0;
         end
         if (frame_end) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 8x4 instance, both run
// against an arithmetic model derived from the count of enabled clocks since reset.
module tb_vga_timing_gen;
   import vga_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_L;
   logic en_d, ack_d, en_s, ack_s;

   logic       hs_d, vs_d, act_d, tick_d, ls_d, fs_d, sc_d, irq_d;
   logic [9:0] row_d, col_d;
   logic [7:0] fc_d;
   logic       hs_s, vs_s, act_s, tick_s, ls_s, fs_s, sc_s, irq_s;
   logic [3:0] row_s, col_s;
   logic [7:0] fc_s;

   vga_timing_gen u_dut_d (
      .clk(clk), .rst_L(rst_L), .en(en_d), .irq_ack(ack_d),
      .HSync(hs_d), .VSync(vs_d), .active(act_d), .row(row_d), .col(col_d),
      .pix_tick(tick_d), .line_start(ls_d), .frame_start(fs_d), .scanline_en(sc_d),
      .vblank_irq(irq_d), .frame_count(fc_d)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(POL_HIGH), .VSYNC_POL(POL_LOW),
      .CLK_DIV(2), .SCAN_DIV(2), .CW(4)
   ) u_dut_s (
      .clk(clk), .rst_L(rst_L), .en(en_s), .irq_ack(ack_s),
      .HSync(hs_s), .VSync(vs_s), .active(act_s), .row(row_s), .col(col_s),
      .pix_tick(tick_s), .line_start(ls_s), .frame_start(fs_s), .scanline_en(sc_s),
      .vblank_irq(irq_s), .frame_count(fc_s)
   );

   typedef struct {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, cdiv, sdiv;
      bit hpol, vpol;
   } mode_t;

   mode_t md[2];
   int    en_cnt[2];
   bit    e_hs[2], e_vs[2], e_act[2], e_tick[2], e_ls[2], e_fs[2], e_sc[2], e_irq[2];
   int    e_row[2], e_col[2], e_fc[2];
   int    n_chk = 0;
   int    n_err = 0;

   task automatic chk(input int m, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL m%0d %s: got %0d expected %0d at %0t", m, name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int m);
      en_cnt[m] = 0;
      e_hs[m] = !md[m].hpol;  e_vs[m] = !md[m].vpol;
      e_act[m] = 0; e_row[m] = 0; e_col[m] = 0;
      e_tick[m] = 0; e_ls[m] = 0; e_fs[m] = 0; e_sc[m] = 0;
      e_irq[m] = 0; e_fc[m] = 0;
   endtask

   // Raster position follows from the number of pixel ticks seen since reset.
   task automatic step(input int m, input bit en, input bit ack);
      int ht, vt, p, h, v, s, hb, vb;
      bit tk, vis;
      ht = md[m].ha + md[m].hfp + md[m].hsw + md[m].hbp;
      vt = md[m].va + md[m].vfp + md[m].vsw + md[m].vbp;
      if (en) begin
         tk  = (en_cnt[m] % md[m].cdiv) == md[m].cdiv - 1;
         p   = en_cnt[m] / md[m].cdiv;
         h   = p % ht;
         v   = (p / ht) % vt;
         s   = ((v < md[m].va) ? v : md[m].va) % md[m].sdiv;
         vis = (h < md[m].ha) && (v < md[m].va);
         hb  = md[m].ha + md[m].hfp;
         vb  = md[m].va + md[m].vfp;
         e_tick[m] = tk;
         e_ls[m]   = tk && h == 0;
         e_fs[m]   = tk && h == 0 && v == 0;
         e_sc[m]   = tk && h == ht - 1 && v < md[m].va && s == md[m].sdiv - 1;
         e_act[m]  = vis;
         e_col[m]  = vis ? h : 0;
         e_row[m]  = vis ? v : 0;
         e_hs[m]   = (h >= hb && h < hb + md[m].hsw) ? md[m].hpol : !md[m].hpol;
         e_vs[m]   = (v >= vb && v < vb + md[m].vsw) ? md[m].vpol : !md[m].vpol;
         if (tk && h == 0 && v == md[m].va) e_irq[m] = 1;
         else if (ack) e_irq[m] = 0;
         en_cnt[m]++;
         e_fc[m] = ((en_cnt[m] / md[m].cdiv) / (ht * vt)) % 256;
      end else begin
         e_tick[m] = 0; e_ls[m] = 0; e_fs[m] = 0; e_sc[m] = 0;
         if (ack) e_irq[m] = 0;
      end
   endtask

   task automatic check(input int m);
      if (m == 0) begin
         chk(0, "hsync", 32'(hs_d), 32'(e_hs[0]));   chk(0, "vsync", 32'(vs_d), 32'(e_vs[0]));
         chk(0, "active", 32'(act_d), 32'(e_act[0])); chk(0, "row", 32'(row_d), e_row[0]);
         chk(0, "col", 32'(col_d), e_col[0]);          chk(0, "pix_tick", 32'(tick_d), 32'(e_tick[0]));
         chk(0, "line_start", 32'(ls_d), 32'(e_ls[0])); chk(0, "frame_start", 32'(fs_d), 32'(e_fs[0]));
         chk(0, "scanline_en", 32'(sc_d), 32'(e_sc[0])); chk(0, "vblank_irq", 32'(irq_d), 32'(e_irq[0]));
         chk(0, "frame_count", 32'(fc_d), e_fc[0]);
      end else begin
         chk(1, "hsync", 32'(hs_s), 32'(e_hs[1]));   chk(1, "vsync", 32'(vs_s), 32'(e_vs[1]));
         chk(1, "active", 32'(act_s), 32'(e_act[1])); chk(1, "row", 32'(row_s), e_row[1]);
         chk(1, "col", 32'(col_s), e_col[1]);          chk(1, "pix_tick", 32'(tick_s), 32'(e_tick[1]));
         chk(1, "line_start", 32'(ls_s), 32'(e_ls[1])); chk(1, "frame_start", 32'(fs_s), 32'(e_fs[1]));
         chk(1, "scanline_en", 32'(sc_s), 32'(e_sc[1])); chk(1, "vblank_irq", 32'(irq_s), 32'(e_irq[1]));
         chk(1, "frame_count", 32'(fc_s), e_fc[1]);
      end
   endtask

   // Called just after a falling edge: drive, take one rising edge, compare on the next falling edge.
   task automatic cycle(input bit e0, input bit a0, input bit e1, input bit a1);
      en_d = e0; ack_d = a0; en_s = e1; ack_s = a1;
      @(posedge clk);
      step(0, e0, a0);
      step(1, e1, a1);
      @(negedge clk);
      check(0);
      check(1);
   endtask

   task automatic do_reset();
      #2 rst_L = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      check(0);
      check(1);
      chk(0, "async_rst_hsync", 32'(hs_d), 32'd1);
      chk(1, "async_rst_frame_count", 32'(fc_s), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check(0);
      check(1);
      rst_L = 1'b1;
   endtask

   initial begin
      int hs_first, hs_low, act_cnt, ls2_d, tick_cnt, ls2_s, fs2_s, sc_n, guard, strobes;
      int sc_k[4];
      md[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 2, 1'b0, 1'b0};
      md[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 2, 2, 1'b1, 1'b0};
      hs_first = 0; hs_low = 0; act_cnt = 0; ls2_d = 0;
      tick_cnt = 0; ls2_s = 0; fs2_s = 0; sc_n = 0;
      sc_k[0] = 0; sc_k[1] = 0; sc_k[2] = 0; sc_k[3] = 0;
      rst_L = 1'b0; en_d = 1'b0; ack_d = 1'b0; en_s = 1'b0; ack_s = 1'b0;
      model_reset(0);
      model_reset(1);
      @(negedge clk);
      check(0);
      check(1);
      chk(0, "reset_hsync", 32'(hs_d), 32'd1);
      chk(1, "reset_hsync_pol_high", 32'(hs_s), 32'd0);
      @(negedge clk);
      rst_L = 1'b1;

      // Free-running after reset; irq_ack pulses on the set edge and the one after.
      for (int k = 1; k <= 1700; k++) begin
         cycle(1'b1, 1'b0, 1'b1, (k == 114) || (k == 115));
         if (k == 1) begin
            chk(0, "first_pix_tick", 32'(tick_d), 32'd1);
            chk(0, "first_frame_start", 32'(fs_d), 32'd1);
            chk(0, "first_active", 32'(act_d), 32'd1);
            chk(0, "first_col", 32'(col_d), 32'd0);
         end
         if (k <= 800) begin
            if (!hs_d) begin
               hs_low++;
               if (hs_first == 0) hs_first = k;
            end
            if (act_d) act_cnt++;
         end
         if (ls_d && k > 1 && ls2_d == 0) ls2_d = k;
         if (k <= 196) begin
            if (tick_s) tick_cnt++;
            if (sc_s && sc_n < 4) begin
               sc_k[sc_n] = k;
               sc_n++;
            end
         end
         if (ls_s && k > 2 && ls2_s == 0) ls2_s = k;
         if (fs_s && k > 2 && fs2_s == 0) fs2_s = k;
         if (k == 16) chk(1, "col_at_7", 32'(col_s), 32'd7);
         if (k == 17) chk(1, "active_after_col7", 32'(act_s), 32'd0);
         if (k == 114) chk(1, "irq_set_wins_over_ack", 32'(irq_s), 32'd1);
         if (k == 115) chk(1, "irq_cleared_by_ack", 32'(irq_s), 32'd0);
      end
      chk(0, "hsync_first_low_edge", hs_first, 657);
      chk(0, "hsync_low_clks", hs_low, 96);
      chk(0, "active_per_line", act_cnt, 640);
      chk(0, "line_period_edge", ls2_d, 801);
      chk(1, "pix_ticks_per_frame", tick_cnt, 98);
      chk(1, "second_line_start", ls2_s, 30);
      chk(1, "second_frame_start", fs2_s, 198);
      chk(1, "scanline_count", sc_n, 2);
      chk(1, "scanline_line1_edge", sc_k[0], 56);
      chk(1, "scanline_line3_edge", sc_k[1], 112);

      // Pause the small raster at the start of pixel h=5 of a visible line.
      guard = 0;
      while (!((en_cnt[1] % 2 == 0) && ((en_cnt[1] / 2) % 14 == 5) && (((en_cnt[1] / 2) / 14) % 7 < 4))
             && guard < 400) begin
         cycle(1'b1, 1'b0, 1'b1, 1'b0);
         guard++;
      end
      chk(1, "hold_point_found", 32'(guard < 400), 32'd1);
      strobes = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         strobes += int'(tick_s) + int'(ls_s) + int'(fs_s) + int'(sc_s);
      end
      chk(1, "hold_strobes", strobes, 0);
      chk(1, "hold_col", 32'(col_s), 32'd4);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk(1, "resume_col", 32'(col_s), 32'd5);
      chk(1, "resume_no_tick", 32'(tick_s), 32'd0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk(1, "resume_tick", 32'(tick_s), 32'd1);

      // Random run/ack with an asynchronous reset partway through.
      for (int i = 0; i < 3000; i++) begin
         cycle(bit'($urandom % 8 != 0), bit'($urandom % 16 == 0),
               bit'($urandom % 8 != 0), bit'($urandom % 16 == 0));
         if (i == 1500) do_reset();
      end

      // 256 small frames to wrap frame_count.
      do_reset();
      for (int k = 1; k <= 50180; k++) begin
         cycle(1'b1, bit'($urandom % 32 == 0), 1'b1, bit'($urandom % 32 == 0));
         if (k == 50175) chk(1, "frame_count_255", 32'(fc_s), 32'd255);
         if (k == 50176) chk(1, "frame_count_wrap", 32'(fc_s), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator that replaces the fixed 640x480 VGA counter block in the VDP video path. It produces sync, blanking, pixel coordinates and frame/line event pulses for any mode set by parameters. It adds a pixel-clock divider, programmable sync polarity, a run enable, a programmable scanline decimation ratio for the SMS line engine, a frame counter and a sticky vblank interrupt. All outputs are registered.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync, in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, asserted sync level (0 = active-low)
- CLK_DIV, 1, clk cycles per pixel (>=1)
- SCAN_DIV, 2, active lines per scanline_en pulse (>=1)
- CW, 10, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  system clock
- rst_L  in  1  reset; one clock, asynchronous, active-low
- en  in  1  run; low freezes all counters
- irq_ack  in  1  clears vblank_irq
- HSync, VSync  out  1  sync outputs at the configured polarity
- active  out  1  pixel is in the visible region
- row, col  out  CW  visible coordinates; 0 outside the visible region
- pix_tick  out  1  one-clk strobe per pixel
- line_start, frame_start  out  1  one-clk strobes at h=0, and at h=0 with v=0
- scanline_en  out  1  one-clk strobe at the end of every SCAN_DIV-th visible line
- vblank_irq  out  1  sticky vblank flag
- frame_count  out  8  completed frames, wraps 255->0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both are computed as localparams.
- div counter: runs 0..CLK_DIV-1 while en=1. tick = en && div==CLK_DIV-1. With CLK_DIV=1, tick = en.
- h counter: 0..H_TOTAL-1, advances on tick, wraps to 0.
- v counter: advances on tick when h==H_TOTAL-1, wraps at V_TOTAL-1.
- frame_count: increments on the v wrap.
- Scanline sub-counter s: 0..SCAN_DIV-1.
  - Advances at each visible line end (tick, h==H_TOTAL-1, v<V_ACTIVE).
  - Is cleared on the v wrap.
- Region decodes:
  - visible: h<H_ACTIVE && v<V_ACTIVE.
  - HSync asserted: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - VSync asserted: the same rule applied to v with the V parameters. VSync spans whole lines.
- Event decodes, all qualified by tick:
  - line_start: h==0.
  - frame_start: h==0 && v==0.
  - scanline_en: h==H_TOTAL-1 && v<V_ACTIVE && s==SCAN_DIV-1.
- vblank_irq:
  - Set on tick with h==0 && v==V_ACTIVE.
  - Cleared by irq_ack.
  - If set and ack occur in the same clk, set wins.
- en=0:
  - div, h, v, s and frame_count hold.
  - pix_tick and all strobes are 0.
  - Level outputs (HSync, VSync, active, row, col) hold.
  - irq_ack still clears vblank_irq.

## Timing
- On each clk edge, every output register captures the decode of the current div/h/v/s state, and the counters then advance. Outputs therefore lag the counter state by exactly 1 clk, uniformly.
- Reset (async, on rst_L falling):
  - Counters and frame_count are 0.
  - vblank_irq is 0.
  - HSync = !HSYNC_POL; VSync = !VSYNC_POL.
  - active, row, col, pix_tick and all strobes are 0.
- First edge after rst_L rises with en=1 and CLK_DIV=1:
  - pix_tick=line_start=frame_start=active=1 and col=0.
  - The counter moves to h=1.
- Reset mid-frame restarts at h=v=0 with no partial strobes.
- Coincident line end and frame end in the same tick: scanline_en fires only if v<V_ACTIVE, so the frame-end line never produces it.
- Default mode period: line = 800 clk, frame = 420000 clk.

## Structure
- Package vga_pkg:
  - default 640x480@60 timing localparams;
  - a sync-polarity enum;
  - a function returning the total from active/fp/sync/bp.
- The existing counter sub-module (parametrised width, clear, en) is instantiated for div, h, v and s. No other sub-modules.
- An elaboration check fails if CW cannot hold H_TOTAL-1 or V_TOTAL-1, or if CLK_DIV or SCAN_DIV is less than 1.

## Test plan
- Default params, en=1:
  - HSync low for 96 clk starting at h=656; line period 800.
  - VSync low for 1600 clk; period 420000.
  - 640x480 active pixels per frame.
- Small mode (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2):
  - pix_tick every 2 clk;
  - line_start every 28 clk;
  - frame_start every 196 clk;
  - col steps 0..7 on ticks.
- Small mode, SCAN_DIV=2: exactly 2 scanline_en per frame, at the ends of visible lines 1 and 3.
- en low for 10 clk mid-line (h=5):
  - no strobes; HSync, row and col held;
  - h resumes from 5.
- vblank_irq:
  - set at the tick with v=4 (small mode), h=0;
  - irq_ack in the same clk keeps it 1;
  - irq_ack next clk clears it.
- Reset and frame_count wrap:
  - rst_L low mid-frame gives the reset values immediately (async), with frame_count 0.
  - After 256 frames, frame_count reads 0 again.
